// File: rtl/sr_word_ctrl.sv
// Word-access controller for a recirculating shift register.
// The LENGTH-bit loop is treated as LENGTH/WIDTH words of WIDTH bits each.
// A free-running position counter tracks which bit is on sr_data_out.
// One read or write is served at a time. The controller waits for the target
// word to rotate past the output, then either splices new bits in (write) or
// samples them (read).
module sr_word_ctrl #(
   parameter int LENGTH = 40,
   parameter int WIDTH  = 4,
   parameter int ADDR_W = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [WIDTH-1:0]          req_wdata,
   output logic                      rsp_valid,
   output logic [WIDTH-1:0]          rsp_rdata,
   output logic                      sr_recirc,
   output logic                      sr_data_in,
   input  logic                      sr_data_out,
   output logic [$clog2(LENGTH)-1:0] sr_pos
);

   localparam int POS_W = $clog2(LENGTH);
   localparam int WORDS = LENGTH / WIDTH;
   localparam int K_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SEEK,
      XFER,
      RESP
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [POS_W-1:0]   pos;
   logic [K_W-1:0]     k;
   logic               lat_write;
   logic [ADDR_W-1:0]  lat_addr;
   logic [WIDTH-1:0]   lat_wdata;
   logic [WIDTH-1:0]   cap;
   logic [WIDTH-1:0]   cap_next;
   logic               accept;
   logic               req_in_range;
   logic               req_at_start;
   logic               lat_at_start;
   logic               k_last;
   logic               pos_last;

   // The position one before a word's base. When pos equals this value,
   // the next edge brings bit 0 of the word onto sr_data_out.
   function automatic logic [POS_W-1:0] start_pos(input logic [ADDR_W-1:0] a);
      int unsigned b;
      b = (32'(a) * WIDTH + LENGTH - 1) % LENGTH;
      return POS_W'(b);
   endfunction

   // Addresses at or beyond WORDS do not touch the register.
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return (32'(a) < WORDS);
   endfunction

   assign accept       = req_valid && (state == IDLE);
   assign req_in_range = in_range(req_addr);
   assign req_at_start = (pos == start_pos(req_addr));
   assign lat_at_start = (pos == start_pos(lat_addr));
   assign k_last       = (k == K_W'(WIDTH - 1));
   assign pos_last     = (pos == POS_W'(LENGTH - 1));
   assign sr_pos       = pos;

   // The bit position follows the rotating loop and never stalls. It wraps at LENGTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos <= '0;
      end else begin
         pos <= pos_last ? '0 : pos + 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and outputs. The register recirculates unless a write is splicing bits.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      sr_recirc  = 1'b1;
      sr_data_in = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (!req_in_range) begin
                  state_next = req_write ? IDLE : RESP;
               end else if (req_at_start) begin
                  state_next = XFER;
               end else begin
                  state_next = SEEK;
               end
            end
         end
         SEEK: begin
            if (lat_at_start) begin
               state_next = XFER;
            end
         end
         XFER: begin
            if (lat_write) begin
               sr_recirc  = 1'b0;
               sr_data_in = lat_wdata[k];
            end
            if (k_last) begin
               state_next = lat_write ? IDLE : RESP;
            end
         end
         RESP: begin
            rsp_valid  = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // This is the captured word with the bit currently on sr_data_out merged in at slot k.
   always_comb begin
      cap_next    = cap;
      cap_next[k] = sr_data_out;
   end

   // Request latching, the bit counter, and read capture.
   // A read's result is published on the same edge that captures its last bit,
   // so it is already stable during the RESP cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         k         <= '0;
         cap       <= '0;
         rsp_rdata <= '0;
      end else begin
         if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cap       <= '0;
            if (!req_write && !req_in_range) begin
               rsp_rdata <= '0;
            end
         end
         if (state == XFER) begin
            k <= k_last ? '0 : k + 1'b1;
            if (!lat_write) begin
               cap <= cap_next;
               if (k_last) begin
                  rsp_rdata <= cap_next;
               end
            end
         end else begin
            k <= '0;
         end
      end
   end

endmodule
